usb_pkt_router: RTL and testbench

// Buffers 32-bit words from the USB3 slave-FIFO read path in a tagged circular FIFO.

---
 rtl/usb_da_pkg.sv | 24 ++
 rtl/tag_fifo.sv | 65 ++++++
 rtl/usb_pkt_router.sv | 168 ++++++++++++++++
 tb/tb_usb_pkt_router.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_da_pkg.sv
// Shared header constants, replay modes and header-code classification
// for the USB packet router.
package usb_da_pkg;

    localparam logic [31:0] HDR_MASK       = 32'hFF0000FF;
    localparam logic [31:0] HDR_MATCH      = 32'hFF0000AA;
    localparam logic [15:0] CODE_SPREAD_A  = 16'h0000;
    localparam logic [15:0] CODE_SPREAD_B  = 16'h000A;
    localparam logic [7:0]  CODE_SINGLE_HI = 8'hA0;
    localparam int unsigned SPREAD_SEGS    = 8;
    localparam int unsigned BASE_A         = 0;
    localparam int unsigned BASE_B         = 8;

    typedef enum logic [1:0] {M_IDLE, M_SPREAD, M_SINGLE, M_DISCARD} mode_e;
    typedef enum logic [1:0] {C_SPREAD_A, C_SPREAD_B, C_SINGLE, C_DROP} code_e;

    function automatic code_e classify_code(input logic [15:0] code, input int unsigned num_ch);
        if (code == CODE_SPREAD_A) return C_SPREAD_A;
        if (code == CODE_SPREAD_B) return C_SPREAD_B;
        if (code[15:8] == CODE_SINGLE_HI && 32'(code[7:0]) < num_ch) return C_SINGLE;
        return C_DROP;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous circular FIFO with a registered read port: rd_data holds the
// entry popped on the previous clock edge.
module tag_fifo #(
    parameter int unsigned W     = 34,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = rd_data_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q];
        end
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/usb_pkt_router.sv
// Tags incoming USB words as header/payload, buffers them, and replays each
// payload word as a one-hot write enable to the DA channel sample RAMs.
module usb_pkt_router
    import usb_da_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned NUM_CH = 24,
    parameter int unsigned SEG_A  = 32,
    parameter int unsigned SEG_B  = 10
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_wren,
    output logic              pkt_drop,
    output logic              busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DATA_W + 2;

    logic          push, pop, fifo_full, fifo_empty, is_hdr;
    logic [AW:0]   fifo_count;
    logic [EW-1:0] rd_entry;
    logic          e_hdr, e_last;
    logic [DATA_W-1:0] e_data;

    logic          hdr_expect_q, hdr_expect_d;
    logic          rd_valid_q, rd_valid_d;
    mode_e         state_q, state_d;
    logic [15:0]   seg_cnt_q, seg_cnt_d, seg_len_q, seg_len_d;
    logic [3:0]    ch_idx_q, ch_idx_d;
    logic [7:0]    base_q, base_d, chan_q, chan_d, spread_ch;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_CH-1:0] out_wren_q, out_wren_d;
    logic          pkt_drop_q, pkt_drop_d;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign pop      = out_ready && !fifo_empty;
    assign is_hdr   = hdr_expect_q && ((in_data[31:0] & HDR_MASK) == HDR_MATCH);

    tag_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (push),
        .push_data ({is_hdr, in_last, in_data}),
        .pop       (pop),
        .rd_data   (rd_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign e_hdr     = rd_entry[EW-1];
    assign e_last    = rd_entry[EW-2];
    assign e_data    = rd_entry[DATA_W-1:0];
    assign spread_ch = base_q + 8'(ch_idx_q);

    assign out_data = out_data_q;
    assign out_wren = out_wren_q;
    assign pkt_drop = pkt_drop_q;
    assign busy     = (fifo_count != '0) || (state_q != M_IDLE) || rd_valid_q;

    // rd_entry is valid the cycle after its pop, so the FSM acts on rd_valid_q.
    always_comb begin
        hdr_expect_d = hdr_expect_q;
        rd_valid_d   = pop;
        state_d      = state_q;
        seg_cnt_d    = seg_cnt_q;
        seg_len_d    = seg_len_q;
        ch_idx_d     = ch_idx_q;
        base_d       = base_q;
        chan_d       = chan_q;
        out_data_d   = out_data_q;
        out_wren_d   = '0;
        pkt_drop_d   = 1'b0;
        if (push) hdr_expect_d = in_last;
        if (rd_valid_q) begin
            unique case (state_q)
                M_IDLE: begin
                    seg_cnt_d = '0;
                    ch_idx_d  = '0;
                    if (e_hdr) begin
                        unique case (classify_code(e_data[23:8], NUM_CH))
                            C_SPREAD_A: begin
                                base_d    = 8'(BASE_A);
                                seg_len_d = 16'(SEG_A);
                                state_d   = e_last ? M_IDLE : M_SPREAD;
                            end
                            C_SPREAD_B: begin
                                base_d    = 8'(BASE_B);
                                seg_len_d = 16'(SEG_B);
                                state_d   = e_last ? M_IDLE : M_SPREAD;
                            end
                            C_SINGLE: begin
                                chan_d  = e_data[15:8];
                                state_d = e_last ? M_IDLE : M_SINGLE;
                            end
                            default: begin
                                pkt_drop_d = 1'b1;
                                state_d    = e_last ? M_IDLE : M_DISCARD;
                            end
                        endcase
                    end else begin
                        pkt_drop_d = 1'b1;
                        state_d    = e_last ? M_IDLE : M_DISCARD;
                    end
                end
                M_SPREAD: begin
                    if (ch_idx_q < 4'(SPREAD_SEGS)) begin
                        out_data_d = e_data;
                        out_wren_d = NUM_CH'(1) << spread_ch;
                        if (seg_cnt_q == seg_len_q - 16'd1) begin
                            seg_cnt_d = '0;
                            ch_idx_d  = ch_idx_q + 1'b1;
                        end else begin
                            seg_cnt_d = seg_cnt_q + 16'd1;
                        end
                    end
                    if (e_last) state_d = M_IDLE;
                end
                M_SINGLE: begin
                    out_data_d = e_data;
                    out_wren_d = NUM_CH'(1) << chan_q;
                    if (e_last) state_d = M_IDLE;
                end
                default: begin
                    if (e_last) state_d = M_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            hdr_expect_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            state_q      <= M_IDLE;
            seg_cnt_q    <= '0;
            seg_len_q    <= '0;
            ch_idx_q     <= '0;
            base_q       <= '0;
            chan_q       <= '0;
            out_data_q   <= '0;
            out_wren_q   <= '0;
            pkt_drop_q   <= 1'b0;
        end else begin
            hdr_expect_q <= hdr_expect_d;
            rd_valid_q   <= rd_valid_d;
            state_q      <= state_d;
            seg_cnt_q    <= seg_cnt_d;
            seg_len_q    <= seg_len_d;
            ch_idx_q     <= ch_idx_d;
            base_q       <= base_d;
            chan_q       <= chan_d;
            out_data_q   <= out_data_d;
            out_wren_q   <= out_wren_d;
            pkt_drop_q   <= pkt_drop_d;
        end
    end

endmodule

// File: tb/tb_usb_pkt_router.sv
// Bench for usb_pkt_router: directed and randomized packets checked against a
// packet-level model that predicts each write event from the header rules.
module tb_usb_pkt_router;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int NUM_CH = 24;
    localparam int SEG_A  = 32;
    localparam int SEG_B  = 10;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] out_wren;
    logic              pkt_drop;
    logic              busy;

    always #5 clock = ~clock;

    usb_pkt_router #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .SEG_A(SEG_A), .SEG_B(SEG_B)) dut (
        .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_ready(out_ready), .out_data(out_data), .out_wren(out_wren),
        .pkt_drop(pkt_drop), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet-level model: each accepted word is interpreted immediately and the
    // write events it should eventually produce are queued in order.
    typedef struct { logic [NUM_CH-1:0] wren; logic [31:0] data; } ev_t;
    ev_t evq[$];
    int  mcount = 0, mode = 0, base = 0, seg = 1, k = 0, ch = 0;
    bit  hdr_exp = 1'b1, pushed_now = 1'b0, m_p, m_q;
    int  exp_drops = 0, seen_drops = 0, cyc = 0, first_wren_cyc = -1;
    int  hist[NUM_CH];

    task automatic model_push(input logic [31:0] w, input bit last);
        ev_t e;
        logic [15:0] code;
        bit hdr;
        hdr = hdr_exp && ((w & 32'hFF0000FF) == 32'hFF0000AA);
        hdr_exp = last;
        code = w[23:8];
        if (mode == 0) begin
            k = 0;
            if (hdr && code == 16'h0000) begin base = 0; seg = SEG_A; mode = last ? 0 : 1; end
            else if (hdr && code == 16'h000A) begin base = 8; seg = SEG_B; mode = last ? 0 : 1; end
            else if (hdr && code[15:8] == 8'hA0 && int'(code[7:0]) < NUM_CH) begin
                ch = int'(code[7:0]); mode = last ? 0 : 2;
            end else begin
                exp_drops++;
                mode = last ? 0 : 3;
            end
        end else begin
            if (mode == 1 && k < 8 * seg) begin
                e.wren = NUM_CH'(1) << (base + k / seg); e.data = w; evq.push_back(e);
            end
            if (mode == 2) begin
                e.wren = NUM_CH'(1) << ch; e.data = w; evq.push_back(e);
            end
            k++;
            if (last) mode = 0;
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        pushed_now = 1'b0;
        if (rst) begin
            mcount = 0; evq.delete(); mode = 0; hdr_exp = 1'b1;
        end else begin
            m_p = in_valid && mcount < DEPTH;
            m_q = out_ready && mcount > 0;
            if (m_p) begin model_push(in_data, in_last); pushed_now = 1'b1; end
            mcount = mcount + int'(m_p) - int'(m_q);
        end
    end

    always @(negedge clock) begin
        ev_t e;
        check("in_ready", in_ready, mcount < DEPTH);
        if (pkt_drop === 1'b1) seen_drops++;
        if (out_wren !== '0) begin
            if (first_wren_cyc < 0) first_wren_cyc = cyc;
            for (int i = 0; i < NUM_CH; i++) if (out_wren[i]) hist[i]++;
            if (evq.size() == 0) begin
                check("unexpected_wren", out_wren, 0);
            end else begin
                e = evq.pop_front();
                check("wren", out_wren, e.wren);
                check("data", out_data, e.data);
            end
        end
    end

    task automatic send(input logic [31:0] w, input bit last, input bit rnd);
        int n = 0;
        if (rnd) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clock); #1; end
        end
        in_data = w; in_last = last; in_valid = 1'b1;
        do begin
            @(posedge clock); #1; n++;
            if (rnd && !pushed_now) out_ready = 1'b1;
        end while (!pushed_now && n < 3000);
        if (!pushed_now) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        out_ready = 1'b1; in_valid = 1'b0;
        while ((mcount > 0 || evq.size() > 0) && n < 5000) begin @(posedge clock); #1; n++; end
        repeat (4) @(posedge clock);
        #1;
        check({tag, "_drained"}, evq.size() == 0 && mcount == 0, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drops"}, seen_drops, exp_drops);
    endtask

    task automatic clear_hist();
        for (int i = 0; i < NUM_CH; i++) hist[i] = 0;
    endtask

    function automatic logic [31:0] hdr_word(input logic [15:0] code);
        return {8'hFF, code, 8'hAA};
    endfunction

    initial begin
        int t0, len;
        logic [15:0] code;
        clear_hist();
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        check("rst_wren", out_wren, 0);
        check("rst_data", out_data, 0);
        check("rst_drop", pkt_drop, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // 1: spread A, 64 words, latency of first payload word
        out_ready = 1'b1; first_wren_cyc = -1; t0 = 0;
        send(32'hFF0000AA, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            send($urandom, i == 63, 1'b0);
            if (i == 0) t0 = cyc;
        end
        drain("t1");
        check("t1_latency", first_wren_cyc - t0, 2);
        check("t1_ch0", hist[0], 32);
        check("t1_ch1", hist[1], 32);

        // 2: spread B, 85 words with random pacing
        clear_hist();
        send(32'hFF000AAA, 1'b0, 1'b1);
        for (int i = 0; i < 85; i++) send($urandom, i == 84, 1'b1);
        drain("t2");
        for (int c = 8; c < 16; c++) check($sformatf("t2_ch%0d", c), hist[c], 10);
        check("t2_ch16", hist[16], 0);

        // 3: bad single code dropped, valid single decoded after it
        clear_hist();
        send(32'hFFA030AA, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send($urandom, i == 2, 1'b1);
        send(32'hFFA013AA, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send($urandom, i == 4, 1'b1);
        drain("t3");
        check("t3_ch19", hist[19], 5);

        // 4: fill FIFO with out_ready low, then release
        clear_hist();
        out_ready = 1'b0;
        send(32'hFF000AAA, 1'b0, 1'b0);
        for (int i = 0; i < 255; i++) send($urandom, i == 254, 1'b0);
        check("t4_full", in_ready, 0);
        check("t4_busy", busy, 1);
        in_data = 32'h0000_0000; in_last = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("t4_full_hold", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        check("t4_ready_rise", in_ready, 1);
        drain("t4");
        for (int c = 8; c < 16; c++) check($sformatf("t4_ch%0d", c), hist[c], 10);

        // 5: orphan word, then reset in the middle of a spread packet
        send(32'h1234_5678, 1'b0, 1'b0);
        send(32'h9ABC_DEF0, 1'b1, 1'b0);
        drain("t5_orphan");
        send(32'hFF0000AA, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) send($urandom, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clock); #1;
        check("t5_rst_wren", out_wren, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_drop", pkt_drop, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", in_ready, 1);
        rst = 1'b0;
        clear_hist();
        send(32'hFFA003AA, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send($urandom, i == 3, 1'b0);
        drain("t5_after");
        check("t5_ch3", hist[3], 4);

        // random packets
        for (int p = 0; p < 8; p++) begin
            case ($urandom_range(0, 4))
                0: code = 16'h0000;
                1: code = 16'h000A;
                2: code = {8'hA0, 8'($urandom_range(0, 40))};
                3: code = 16'($urandom);
                default: code = 16'h5555;
            endcase
            len = $urandom_range(1, 40);
            if (code == 16'h5555) send($urandom & 32'h00FF_FF00, len == 0, 1'b1);
            else send(hdr_word(code), 1'b0, 1'b1);
            for (int i = 0; i < len; i++) send($urandom, i == len - 1, 1'b1);
        end
        drain("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
